ram_burst_reader: RTL

Read-side controller for the dual-port `ram` block. On a start request it fetches a contiguous burst of words from the RAM read port and delivers them in order on a valid/ready stream. It handles the RAM's one-cycle registered read latency with a 2-entry output buffer, so back-pressure never loses or duplicates a word. It sits between the `ram` read port and any downstream consumer; the RAM write port stays with the producer.

---
 rtl/ram_burst_reader_if.sv | 28 ++
 rtl/ram_burst_reader.sv | 118 +++++++++++
 2 files changed

// File: rtl/ram_burst_reader_if.sv
// Bundle between the burst reader, the RAM read port and the stream consumer.
// master: the reader itself; slave: the requester, RAM and consumer side.
interface ram_burst_reader_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   length;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] ram_data;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, base_addr, length, ram_data, ready,
        output r_addr, data, valid, last, busy, done
    );

    modport slave (
        output start, base_addr, length, ram_data, ready,
        input  r_addr, data, valid, last, busy, done
    );
endinterface

// File: rtl/ram_burst_reader.sv
// Fetches a contiguous burst from a RAM with one-cycle read latency and streams
// it out over valid/ready through a 2-entry FIFO, so back-pressure never drops words.
module ram_burst_reader #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_burst_reader_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;
    localparam logic [ADDR_WIDTH:0]   LenOne  = 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   left_q, left_d;
    logic                  inflight_q, inflight_last_q;

    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [1:0]            fifo_last_q;
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            count_q;

    logic       issue, push, pop, head_valid, head_last;
    logic [2:0] occ_next;

    assign head_valid = (count_q != 2'd0);
    assign head_last  = fifo_last_q[rd_ptr_q];
    assign pop        = head_valid && bus.ready;
    assign push       = inflight_q;

    // Occupancy once this cycle's pop and the inflight word settle; a new read
    // may only issue if its word is guaranteed a free slot.
    assign occ_next = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue    = (state_q == StRun) && (left_q != '0) && (occ_next < 3'd2);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start && (bus.length != '0)) begin
                    addr_d  = bus.base_addr;
                    left_d  = bus.length;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (issue) begin
                    addr_d = addr_q + AddrOne;
                    left_d = left_q - LenOne;
                end
                if (pop && head_last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            left_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            left_q          <= left_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && (left_q == LenOne);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= bus.ram_data;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.r_addr = addr_q;
    assign bus.valid  = head_valid;
    assign bus.data   = head_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign bus.last   = head_valid && head_last;
    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = (state_q == StDone);

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == 2'd2)));

endmodule
